// File: rtl/alu.sv
// Registered ALU: 13 arithmetic/logic ops selected by SEL; the result is produced 9 bits wide
// as {Cout,Z}, one cycle after the inputs are sampled.
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       SEL,
   output logic [WIDTH-1:0] Z,
   output logic             Cout
);

   localparam logic [4:0] OP_PASS_A = 5'd0;
   localparam logic [4:0] OP_PASS_B = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_SUB    = 5'd4;
   localparam logic [4:0] OP_ADD    = 5'd5;
   localparam logic [4:0] OP_INC    = 5'd6;
   localparam logic [4:0] OP_ADD1   = 5'd7;
   localparam logic [4:0] OP_SUB1   = 5'd8;
   localparam logic [4:0] OP_XOR    = 5'd9;
   localparam logic [4:0] OP_NOT    = 5'd10;
   localparam logic [4:0] OP_SHL    = 5'd11;
   localparam logic [4:0] OP_SHR    = 5'd12;

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;
   logic [WIDTH:0] res;

   assign a_ext = {1'b0, A};
   assign b_ext = {1'b0, B};

   // Zero-extended operands make bit WIDTH the carry, or the borrow for subtraction.
   always_comb begin
      res = '0;
      case (SEL)
         OP_PASS_A: res = a_ext;
         OP_PASS_B: res = b_ext;
         OP_AND:    res = a_ext & b_ext;
         OP_OR:     res = a_ext | b_ext;
         OP_SUB:    res = a_ext - b_ext;
         OP_ADD:    res = a_ext + b_ext;
         OP_INC:    res = a_ext + ONE;
         OP_ADD1:   res = a_ext + b_ext + ONE;
         OP_SUB1:   res = a_ext - b_ext - ONE;
         OP_XOR:    res = a_ext ^ b_ext;
         OP_NOT:    res = {1'b0, ~A};
         OP_SHL:    res = {A, 1'b0};
         OP_SHR:    res = {A[0], 1'b0, A[WIDTH-1:1]};
         default:   res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Z    <= '0;
         Cout <= 1'b0;
      end else begin
         Z    <= res[WIDTH-1:0];
         Cout <= res[WIDTH];
      end
   end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases, reset behaviour and random ops against an arithmetic model.
module tb_alu;

   logic       clk;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [4:0] SEL;
   logic [7:0] Z;
   logic       Cout;

   int errors = 0;
   int checks = 0;

   alu #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .SEL  (SEL),
      .Z    (Z),
      .Cout (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain integer arithmetic, reduced modulo 512 to give {Cout,Z}.
   function automatic logic [8:0] model(input int a, input int b, input int sel);
      int r;
      case (sel)
         0:  r = a;
         1:  r = b;
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a - b;
         5:  r = a + b;
         6:  r = a + 1;
         7:  r = a + b + 1;
         8:  r = a - b - 1;
         9:  r = a ^ b;
         10: r = 255 - a;
         11: r = a * 2;
         12: r = (a / 2) + (a % 2) * 256;
         default: r = 0;
      endcase
      r = ((r % 512) + 512) % 512;
      return r[8:0];
   endfunction

   task automatic check(input string tag, input logic [7:0] ez, input logic ec);
      checks++;
      assert (Z === ez && Cout === ec)
      else begin
         errors++;
         $error("FAIL %s: observed Z=%h Cout=%b expected Z=%h Cout=%b", tag, Z, Cout, ez, ec);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [4:0] sel,
                       input string tag, input logic [7:0] ez, input logic ec);
      @(negedge clk);
      A = a; B = b; SEL = sel;
      @(posedge clk);
      #1;
      check(tag, ez, ec);
   endtask

   initial begin
      logic [8:0] exp;
      logic [7:0] ra, rb;
      logic [4:0] rs;

      rst = 1'b1; A = 8'h5A; B = 8'hA5; SEL = 5'd5;
      #1;
      check("reset_async", 8'h00, 1'b0);
      @(posedge clk); #1;
      check("reset_held", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      step(8'h03, 8'h0C, 5'd0,  "pass_a", 8'h03, 1'b0);
      step(8'h03, 8'h0C, 5'd1,  "pass_b", 8'h0C, 1'b0);
      step(8'h03, 8'h0C, 5'd2,  "and",    8'h00, 1'b0);
      step(8'h03, 8'h0C, 5'd3,  "or",     8'h0F, 1'b0);
      step(8'h03, 8'h0C, 5'd5,  "add",    8'h0F, 1'b0);
      step(8'hFF, 8'h01, 5'd5,  "add_carry", 8'h00, 1'b1);
      step(8'h16, 8'h0C, 5'd4,  "sub",    8'h0A, 1'b0);
      step(8'h0C, 8'h16, 5'd4,  "sub_borrow", 8'hF6, 1'b1);
      step(8'h06, 8'hAA, 5'd6,  "inc",    8'h07, 1'b0);
      step(8'hFF, 8'h00, 5'd6,  "inc_wrap", 8'h00, 1'b1);
      step(8'h06, 8'hEC, 5'd7,  "add1",   8'hF3, 1'b0);
      step(8'hEC, 8'h06, 5'd8,  "sub1",   8'hE5, 1'b0);
      step(8'h06, 8'h06, 5'd8,  "sub1_eq", 8'hFF, 1'b1);
      step(8'h3C, 8'h0F, 5'd9,  "xor",    8'h33, 1'b0);
      step(8'h3C, 8'h0F, 5'd10, "not",    8'hC3, 1'b0);
      step(8'h81, 8'h00, 5'd11, "shl",    8'h02, 1'b1);
      step(8'h81, 8'h00, 5'd12, "shr",    8'h40, 1'b1);
      step(8'h06, 8'hEC, 5'd31, "default", 8'h00, 1'b0);
      step(8'h06, 8'hEC, 5'd13, "default_13", 8'h00, 1'b0);

      // Input changes between edges must not reach the outputs early.
      step(8'hFF, 8'h01, 5'd5, "pre_hold", 8'h00, 1'b1);
      @(negedge clk);
      A = 8'h10; B = 8'h20; SEL = 5'd3;
      #1;
      check("hold_between_edges", 8'h00, 1'b1);
      @(posedge clk); #1;
      check("hold_next_edge", 8'h30, 1'b0);

      // Asynchronous reset mid-stream, then release.
      step(8'hFF, 8'h01, 5'd5, "rst_setup", 8'h00, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_immediate", 8'h00, 1'b0);
      @(posedge clk); #1;
      check("rst_edge1", 8'h00, 1'b0);
      @(posedge clk); #1;
      check("rst_edge2", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_released_pre_edge", 8'h00, 1'b0);
      @(posedge clk); #1;
      check("rst_release_load", 8'h00, 1'b1);

      for (int i = 0; i < 300; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 5'($urandom_range(0, 31));
         exp = model(int'(ra), int'(rb), int'(rs));
         step(ra, rb, rs, $sformatf("rand_%0d_sel%0d", i, rs), exp[7:0], exp[8]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
